// File: rtl/axi_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi_trace_ctrl
// Brief    : AXI address-trigger and capture-window controller that gates a
//            trace dumper and keeps saturating beat/error statistics.
// Revision : 1.0 - initial release
// ============================================================================

package axi_trace_pkg;
  typedef struct packed {
    logic [31:0] addr;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    axi_b_t  b;
    logic    b_valid;
    axi_r_t  r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_trace_ctrl #(
  parameter type         axi_req_t  = axi_trace_pkg::axi_req_t,
  parameter type         axi_resp_t = axi_trace_pkg::axi_resp_t,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned CntWidth   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  axi_req_t             axi_req_i,
  input  axi_resp_t            axi_resp_i,
  input  logic                 arm_i,
  input  logic                 disarm_i,
  input  logic [AddrWidth-1:0] trig_addr_i,
  input  logic [AddrWidth-1:0] trig_mask_i,
  input  logic                 trig_on_write_i,
  input  logic                 trig_on_read_i,
  input  logic [CntWidth-1:0]  window_len_i,
  output logic                 log_en_o,
  output logic [1:0]           state_o,
  output logic                 done_o,
  output logic [CntWidth-1:0]  aw_cnt_o,
  output logic [CntWidth-1:0]  ar_cnt_o,
  output logic [CntWidth-1:0]  w_cnt_o,
  output logic [CntWidth-1:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [CntWidth-1:0] r_remaining, w_remaining_nxt;
  logic                r_unlimited, w_unlimited_nxt;
  logic [CntWidth-1:0] r_aw_cnt, r_ar_cnt, r_w_cnt, r_err_cnt;
  logic                w_clr_cnt, w_log;

  logic w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs;
  logic w_aw_match, w_ar_match, w_trig, w_err;
  logic [CntWidth-1:0] w_nhs;
  logic w_unused;

  assign w_aw_hs = axi_req_i.aw_valid & axi_resp_i.aw_ready;
  assign w_ar_hs = axi_req_i.ar_valid & axi_resp_i.ar_ready;
  assign w_w_hs  = axi_req_i.w_valid  & axi_resp_i.w_ready;
  assign w_b_hs  = axi_resp_i.b_valid & axi_req_i.b_ready;
  assign w_r_hs  = axi_resp_i.r_valid & axi_req_i.r_ready;

  assign w_aw_match = ((axi_req_i.aw.addr ^ trig_addr_i) & trig_mask_i) == '0;
  assign w_ar_match = ((axi_req_i.ar.addr ^ trig_addr_i) & trig_mask_i) == '0;
  assign w_trig = (trig_on_write_i & w_aw_hs & w_aw_match) |
                  (trig_on_read_i  & w_ar_hs & w_ar_match);

  // Only the final R beat carries the burst outcome worth counting.
  assign w_err = (w_b_hs & axi_resp_i.b.resp[1]) |
                 (w_r_hs & axi_resp_i.r.last & axi_resp_i.r.resp[1]);

  assign w_nhs    = CntWidth'(w_aw_hs) + CntWidth'(w_ar_hs);
  assign w_unused = ^{axi_req_i.w, axi_resp_i.r.data,
                      axi_resp_i.b.resp[0], axi_resp_i.r.resp[0]};

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_unlimited_nxt = r_unlimited;
    w_clr_cnt       = 1'b0;
    w_log           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm_i && !disarm_i) begin
          w_state_nxt = S_ARMED;
          w_clr_cnt   = 1'b1;
        end
      end
      S_ARMED: begin
        if (disarm_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_trig) begin
          // The trigger cycle's own handshakes consume window budget.
          w_log           = 1'b1;
          w_unlimited_nxt = (window_len_i == '0);
          if ((window_len_i != '0) && (w_nhs >= window_len_i)) begin
            w_state_nxt     = S_DONE;
            w_remaining_nxt = '0;
          end else begin
            w_state_nxt     = S_CAPTURE;
            w_remaining_nxt = window_len_i - w_nhs;
          end
        end else if (arm_i) begin
          w_clr_cnt = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_log = 1'b1;
        if (disarm_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_remaining_nxt = (r_remaining > w_nhs) ? (r_remaining - w_nhs) : '0;
          if (!r_unlimited && (w_remaining_nxt == '0)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (disarm_i) begin
          w_state_nxt = S_IDLE;
        end else if (arm_i) begin
          w_state_nxt = S_ARMED;
          w_clr_cnt   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? (v + CntWidth'(1)) : v;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_unlimited <= 1'b0;
      r_aw_cnt    <= '0;
      r_ar_cnt    <= '0;
      r_w_cnt     <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_unlimited <= w_unlimited_nxt;
      if (w_clr_cnt) begin
        r_aw_cnt  <= '0;
        r_ar_cnt  <= '0;
        r_w_cnt   <= '0;
        r_err_cnt <= '0;
      end else if (w_log) begin
        r_aw_cnt  <= sat_inc(r_aw_cnt, w_aw_hs);
        r_ar_cnt  <= sat_inc(r_ar_cnt, w_ar_hs);
        r_w_cnt   <= sat_inc(r_w_cnt, w_w_hs);
        r_err_cnt <= sat_inc(r_err_cnt, w_err);
      end
    end
  end

  assign log_en_o  = w_log;
  assign state_o   = r_state;
  assign done_o    = (r_state == S_DONE);
  assign aw_cnt_o  = r_aw_cnt;
  assign ar_cnt_o  = r_ar_cnt;
  assign w_cnt_o   = r_w_cnt;
  assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axi_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_trace_ctrl
// Brief    : Directed and randomized checks of axi_trace_ctrl against a
//            window-budget reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_trace_ctrl;
  import axi_trace_pkg::*;

  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int P_IDLE = 0, P_ARMED = 1, P_CAPTURE = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  axi_req_t  req;
  axi_resp_t resp;
  logic arm, disarm, ton_w, ton_r;
  logic [31:0] taddr, tmask;
  logic [CW-1:0] wlen;
  logic log_en, done;
  logic [1:0] state;
  logic [CW-1:0] aw_cnt, ar_cnt, w_cnt, err_cnt;

  axi_trace_ctrl #(.AddrWidth(32), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_resp_i(resp),
    .arm_i(arm), .disarm_i(disarm), .trig_addr_i(taddr), .trig_mask_i(tmask),
    .trig_on_write_i(ton_w), .trig_on_read_i(ton_r), .window_len_i(wlen),
    .log_en_o(log_en), .state_o(state), .done_o(done),
    .aw_cnt_o(aw_cnt), .ar_cnt_o(ar_cnt), .w_cnt_o(w_cnt), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase, handshakes seen since trigger, and counts.
  int m_ph = P_IDLE, m_seen = 0, m_len = 0;
  bit m_unl = 1'b0;
  int c_aw = 0, c_ar = 0, c_w = 0, c_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_clear();
    c_aw = 0; c_ar = 0; c_w = 0; c_err = 0;
  endtask

  task automatic quiet();
    req = '0; resp = '0; arm = 1'b0; disarm = 1'b0;
  endtask

  // Called at a negedge with inputs driven; returns at the following negedge.
  task automatic step();
    bit aw_hs, ar_hs, w_hs, b_hs, r_hs, trig, err, exp_log;
    int nh;
    aw_hs = req.aw_valid && resp.aw_ready;
    ar_hs = req.ar_valid && resp.ar_ready;
    w_hs  = req.w_valid && resp.w_ready;
    b_hs  = resp.b_valid && req.b_ready;
    r_hs  = resp.r_valid && req.r_ready;
    trig  = (ton_w && aw_hs && ((req.aw.addr & tmask) == (taddr & tmask))) ||
            (ton_r && ar_hs && ((req.ar.addr & tmask) == (taddr & tmask)));
    err   = (b_hs && resp.b.resp >= 2) || (r_hs && resp.r.last && resp.r.resp >= 2);
    nh    = int'(aw_hs) + int'(ar_hs);
    exp_log = (m_ph == P_CAPTURE) || (m_ph == P_ARMED && trig && !disarm);
    #1 chk("log_en", log_en, exp_log);
    @(posedge clk);
    if (exp_log) begin
      c_aw  = sat(c_aw + int'(aw_hs));
      c_ar  = sat(c_ar + int'(ar_hs));
      c_w   = sat(c_w + int'(w_hs));
      c_err = sat(c_err + int'(err));
    end
    case (m_ph)
      P_IDLE: if (arm && !disarm) begin m_ph = P_ARMED; model_clear(); end
      P_ARMED: begin
        if (disarm) m_ph = P_IDLE;
        else if (trig) begin
          m_unl  = (wlen == 0);
          m_len  = int'(wlen);
          m_seen = nh;
          m_ph   = (!m_unl && m_seen >= m_len) ? P_DONE : P_CAPTURE;
        end else if (arm) model_clear();
      end
      P_CAPTURE: begin
        if (disarm) m_ph = P_IDLE;
        else begin
          m_seen += nh;
          if (!m_unl && m_seen >= m_len) m_ph = P_DONE;
        end
      end
      default: begin
        if (disarm) m_ph = P_IDLE;
        else if (arm) begin m_ph = P_ARMED; model_clear(); end
      end
    endcase
    #1;
    chk("state", state, m_ph);
    chk("done", done, m_ph == P_DONE);
    chk("aw_cnt", aw_cnt, c_aw);
    chk("ar_cnt", ar_cnt, c_ar);
    chk("w_cnt", w_cnt, c_w);
    chk("err_cnt", err_cnt, c_err);
    @(negedge clk);
  endtask

  task automatic pulse_arm();
    quiet(); arm = 1'b1; step();
  endtask

  task automatic hs(input bit aw_en, input logic [31:0] aw_a,
                    input bit ar_en, input logic [31:0] ar_a);
    quiet();
    req.aw_valid = aw_en; resp.aw_ready = aw_en; req.aw.addr = aw_a;
    req.ar_valid = ar_en; resp.ar_ready = ar_en; req.ar.addr = ar_a;
    step();
  endtask

  task automatic w_beats(input int n);
    for (int i = 0; i < n; i++) begin
      quiet(); req.w_valid = 1'b1; resp.w_ready = 1'b1; step();
    end
  endtask

  initial begin
    quiet();
    taddr = 32'h1000; tmask = 32'hFFFF_F000; ton_w = 1'b1; ton_r = 1'b0; wlen = 3;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_log", log_en, 0);
    chk("rst_state", state, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", {aw_cnt, ar_cnt, w_cnt, err_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write trigger, window of three address handshakes.
    pulse_arm();
    hs(1, 32'h0800, 0, 0);
    chk("t1_still_armed", state, P_ARMED);
    hs(1, 32'h1234, 0, 0);
    hs(1, 32'h2000, 0, 0);
    hs(0, 0, 1, 32'h2000);
    chk("t1_done", state, P_DONE);
    chk("t1_aw", aw_cnt, 2);
    chk("t1_ar", ar_cnt, 1);

    // AW and AR both match in the trigger cycle.
    pulse_arm();
    wlen = 2; ton_r = 1'b1;
    hs(1, 32'h1000, 1, 32'h1ABC);
    chk("t2_done", state, P_DONE);
    chk("t2_aw", aw_cnt, 1);
    chk("t2_ar", ar_cnt, 1);
    quiet(); step();

    // Unlimited window with error responses.
    pulse_arm();
    wlen = 0;
    hs(1, 32'h1FFC, 0, 0);
    w_beats(5);
    quiet(); resp.b_valid = 1'b1; req.b_ready = 1'b1; resp.b.resp = 2'd2; step();
    quiet(); resp.r_valid = 1'b1; req.r_ready = 1'b1; resp.r.last = 1'b1;
    resp.r.resp = 2'd3; step();
    quiet(); disarm = 1'b1; step();
    chk("t3_idle", state, P_IDLE);
    chk("t3_w", w_cnt, 5);
    chk("t3_err", err_cnt, 2);
    quiet(); step();
    chk("t3_w_hold", w_cnt, 5);

    // Saturation, then simultaneous arm/disarm in CAPTURE.
    pulse_arm();
    hs(1, 32'h1000, 0, 0);
    w_beats(20);
    chk("t4_w_sat", w_cnt, CMAX);
    quiet(); arm = 1'b1; disarm = 1'b1; step();
    chk("t5_idle", state, P_IDLE);
    quiet(); #1 chk("t5_nolog", log_en, 0);
    @(negedge clk);

    // Asynchronous reset mid-capture.
    pulse_arm();
    hs(1, 32'h1000, 0, 0);
    w_beats(3);
    quiet(); req.aw_valid = 1'b1; resp.aw_ready = 1'b1; req.aw.addr = 32'h1000;
    #1 chk("t6_pre_log", log_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_log", log_en, 0);
    chk("t6_state", state, 0);
    chk("t6_cnt", {aw_cnt, ar_cnt, w_cnt, err_cnt}, 0);
    m_ph = P_IDLE; m_seen = 0; model_clear();
    @(negedge clk);
    quiet(); rst_n = 1'b1;

    // Randomized traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 64 == 0) begin
        taddr = $urandom & 32'hFFFF_F000;
        case ($urandom_range(0, 3))
          0: tmask = 32'hFFFF_F000;
          1: tmask = 32'hFFFF_0000;
          2: tmask = 32'hFFFF_FFFF;
          default: tmask = 32'h0;
        endcase
        ton_w = ($urandom_range(0, 3) != 0);
        ton_r = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 7) == 0) wlen = CW'($urandom_range(0, 6));
      req  = axi_req_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      resp = axi_resp_t'({$urandom, $urandom, $urandom});
      if ($urandom_range(0, 1) != 0) req.aw.addr = (taddr & tmask) | ($urandom & ~tmask);
      if ($urandom_range(0, 1) != 0) req.ar.addr = (taddr & tmask) | ($urandom & ~tmask);
      arm    = ($urandom_range(0, 19) == 0) && !req.aw_valid && !req.ar_valid;
      disarm = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
